// File: rtl/hilo_muldiv_pkg.sv
// rtl/hilo_muldiv_pkg.sv - shared types and constants for the HI/LO multiply/divide unit
// Package muldiv_pkg:
//   state_e      sequencer states IDLE, MUL, DIV, FIXUP, DONE
//   OP_*         op[1:0] encodings (op[0]: 0=mul 1=div, op[1]: 1=unsigned)
//   MULDIV_ITER  iterations per multiply/divide for the 32-bit datapath
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int MULDIV_ITER = 32;

endpackage

// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - request/result bundle between the control unit and the multiply/divide unit
// Signals:
//   start     one-cycle request (accepted only when the unit is idle)
//   op        op[0]: 0=multiply 1=divide, op[1]: 1=unsigned
//   a, b      operands from the A and B registers
//   hi, lo    result toward the HI and LO registers
//   ready     one-cycle pulse when hi/lo are updated
//   busy      operation in flight
//   div_zero  last accepted divide had a zero divisor
// Modports: master (control unit side), slave (multiply/divide unit side).
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ready;
    logic             busy;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, ready, busy, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, ready, busy, div_zero
    );
endinterface

// File: rtl/hilo_muldiv_divstep.sv
// rtl/hilo_muldiv_divstep.sv - one combinational restoring-division step
// Module muldiv_divstep:
//   rem_in   partial remainder (always below divisor)
//   dvd_msb  next dividend bit shifted into the remainder
//   divisor  divisor magnitude
//   rem_out  next partial remainder
//   q_bit    quotient bit produced by this step
module muldiv_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_msb};
        diff    = shifted - {1'b0, divisor};
        // Since rem_in < divisor, a clear top bit means the subtraction
        // did not borrow and the result already fits in WIDTH bits.
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative signed multiply/divide unit feeding the HI/LO registers
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    hilo_muldiv_if.slave (start/op/a/b in, hi/lo/ready/busy/div_zero out)
// Parameters: WIDTH operand width, CNT_W iteration counter width (2^CNT_W > WIDTH).
// Optional: define HILO_MULDIV_UNSIGNED_EN to honour op[1] (multu/divu).
// Datapath: one 2*WIDTH+1 accumulator shared by the Booth multiplier
// ({upper, multiplier, q-1}) and the restoring divider ({remainder, dividend/quotient, 0}).
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    hilo_muldiv_if.slave bus
);
    localparam int ACC_W = 2 * WIDTH + 1;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dz_q, dz_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
`ifdef HILO_MULDIV_UNSIGNED_EN
    logic               uns_q, uns_d;
`else
    logic               unused_op1;
    assign unused_op1 = bus.op[1];
`endif

    logic [WIDTH:0]     up_ext;
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     mul_sum;
    logic [ACC_W-1:0]   mul_next;
    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;
    logic               last_iter;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_in  (acc_q[2*WIDTH:WIDTH+1]),
        .dvd_msb (acc_q[WIDTH]),
        .divisor (opnd_q),
        .rem_out (div_rem),
        .q_bit   (div_qbit)
    );

    // Booth step: add/subtract the multiplicand on a one-bit-wider upper
    // half so the -2^(WIDTH-1) multiplicand cannot overflow, then shift.
    always_comb begin
        up_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
        m_ext  = {opnd_q[WIDTH-1], opnd_q};
        case (acc_q[1:0])
            2'b01:   mul_sum = up_ext + m_ext;
            2'b10:   mul_sum = up_ext - m_ext;
            default: mul_sum = up_ext;
        endcase
`ifdef HILO_MULDIV_UNSIGNED_EN
        if (uns_q) begin
            mul_sum = {1'b0, acc_q[2*WIDTH:WIDTH+1]}
                    + (acc_q[1] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        end
`endif
        mul_next = {mul_sum, acc_q[WIDTH:1]};
    end

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`ifdef HILO_MULDIV_UNSIGNED_EN
        uns_d   = uns_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dz_d  = 1'b0;
                    cnt_d = '0;
`ifdef HILO_MULDIV_UNSIGNED_EN
                    uns_d = bus.op[1];
`endif
                    if (!bus.op[0]) begin
                        opnd_d  = bus.a;
                        acc_d   = {{WIDTH{1'b0}}, bus.b, 1'b0};
                        state_d = MUL;
                    end else if (bus.b == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        opnd_d  = mag(bus.b);
                        acc_d   = {{WIDTH{1'b0}}, mag(bus.a), 1'b0};
                        qneg_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        rneg_d  = bus.a[WIDTH-1];
`ifdef HILO_MULDIV_UNSIGNED_EN
                        if (bus.op[1]) begin
                            opnd_d = bus.b;
                            acc_d  = {{WIDTH{1'b0}}, bus.a, 1'b0};
                            qneg_d = 1'b0;
                            rneg_d = 1'b0;
                        end
`endif
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    hi_d    = mul_next[2*WIDTH:WIDTH+1];
                    lo_d    = mul_next[WIDTH:1];
                    state_d = DONE;
                end
            end
            DIV: begin
                // Dividend shifts out of the top of the low half while
                // quotient bits shift in at its bottom.
                acc_d = {div_rem, acc_q[WIDTH-1:1], div_qbit, 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                lo_d    = qneg_q ? (~acc_q[WIDTH:1] + 1'b1) : acc_q[WIDTH:1];
                hi_d    = rneg_q ? (~acc_q[2*WIDTH:WIDTH+1] + 1'b1)
                                 : acc_q[2*WIDTH:WIDTH+1];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`ifdef HILO_MULDIV_UNSIGNED_EN
            uns_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`ifdef HILO_MULDIV_UNSIGNED_EN
            uns_q   <= uns_d;
`endif
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.ready    = (state_q == DONE);
    assign bus.busy     = (state_q == MUL) || (state_q == DIV) || (state_q == FIXUP);
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv
module tb_hilo_muldiv;
    import muldiv_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    hilo_muldiv_if #(.WIDTH(32)) bus ();

    hilo_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start an op at edge 0, optionally re-pulse start (a=9) in cycle rep,
    // then watch up to 40 cycles for ready and check the outcome.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int exp_lat, input int rep);
        int          ready_cyc;
        int          busy_cnt;
        logic        hold_err;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        ready_cyc = 0;
        busy_cnt  = 0;
        hold_err  = 1'b0;
        @(negedge clk);
        prev_hi   = bus.hi;
        prev_lo   = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.busy) begin
                busy_cnt++;
                if (bus.hi !== prev_hi || bus.lo !== prev_lo) hold_err = 1'b1;
            end
            if (bus.ready) begin
                ready_cyc = c;
                break;
            end
            bus.start = (c == rep);
            if (c == rep) bus.a = 32'd9;
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, 64'(ready_cyc), 64'(exp_lat));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check({tag, ".hold"}, 64'(hold_err), 64'd0);
        check({tag, ".hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, ".div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
        @(negedge clk);
        check({tag, ".ready_pulse"}, 64'(bus.ready), 64'd0);
    endtask

    initial begin
        int ready_seen;
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);
        check("reset.flags", 64'({bus.ready, bus.busy, bus.div_zero}), 64'd0);
        reset = 1'b1;

        run_op("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MULDIV_ITER + 1, 0);
        run_op("mult_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33, 0);
        run_op("mult_max_max", OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1, 1'b0, 33, 0);
        run_op("mult_m1_m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 33, 0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, MULDIV_ITER + 2, 0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 0);
        run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 0);
        run_op("div_setup", OP_DIV, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 34, 0);
        run_op("div_zero", OP_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1, 0);
        repeat (3) @(negedge clk);
        check("div_zero.sticky", 64'(bus.div_zero), 64'd1);
        run_op("mult_restart", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 5);

        // Reset in cycle 10 of a divide discards it.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset.hi", 64'(bus.hi), 64'd0);
        check("midreset.lo", 64'(bus.lo), 64'd0);
        check("midreset.flags", 64'({bus.ready, bus.busy, bus.div_zero}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        ready_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready) ready_seen++;
        end
        check("midreset.no_ready", 64'(ready_seen), 64'd0);
        run_op("mult_6_7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, 0);

`ifdef HILO_MULDIV_UNSIGNED_EN
        run_op("divu", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, 1'b0, 34, 0);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, 33, 0);
`else
        run_op("op3_signed", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'h0, 1'b0, 34, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
